join_match_unit: RTL and testbench
==================================

// Module: join_match_unit
// PURPOSE
//  Clocked, parametrised join (matching) stage of the data-driven pipeline. Packets flagged
//  for joining wait in a direct-mapped matching memory (MM) until the partner operand
//  (same node, same generation, opposite L/R) arrives. The two operands then leave as one
//  fused packet. Non-join packets bypass the MM. Sits between the input router and FIRE/FU.
// PARAMETERS
//  DEST_W  3   destination field width
//  GEN_W   8   generation/colour field width
//  NODE_W  7   node-number field width (match key together with GEN)
//  DATA_W  16  operand data width
//  IDX_W   5   MM index width; DEPTH = 2**IDX_W entries, index = NODE[IDX_W-1:0]
//  IN_W = DEST_W+GEN_W+NODE_W+4+DATA_W (derived); OUT_W = IN_W+DATA_W (derived)
// PORTS
//  CLK         in   1       clock, rising edge
//  MR          in   1       master reset, asynchronous, active-high
//  Send_in     in   1       input packet valid (level, active-high)
//  Ack_out     out  1       input accepted this cycle when Send_in&Ack_out
//  PACKET_IN   in   IN_W    {DEST,GEN,NODE,LR,JOIN,OVF,RSV,DATA}
//  Send_out    out  1       output packet valid
//  Ack_in      in   1       downstream ready; transfer when Send_out&Ack_in
//  PACKET_OUT  out  OUT_W   {DEST,GEN,NODE,LR=0,JOIN,OVF,RSV,DATA_L,DATA_R}
//  MM_OCC      out  IDX_W+1 count of occupied MM entries
// BEHAVIOUR
//  - Reset (MR=1, async): all MM valid bits 0, MM_OCC=0, Send_out=0, PACKET_OUT=0, Ack_out=0.
//    Reset mid-operation discards waiting operands and any pending output; no packet emitted.
//  - Single output register. Ack_out = ~MR & (~Send_out | Ack_in) & ~stall.
//  - Accept (Send_in&Ack_out), JOIN=0: bypass; next cycle Send_out=1, DATA_L=DATA, DATA_R=0.
//  - Accept, JOIN=1, slot idx empty: write {GEN,NODE,LR,DEST,DATA}, valid=1, MM_OCC+1;
//    no output.
//  - Accept, JOIN=1, slot valid, key (GEN,NODE) equal, LR opposite: slot freed, MM_OCC-1;
//    next cycle fused packet: DATA_L = operand with LR=0, DATA_R = operand with LR=1 (order of
//    arrival irrelevant); DEST/GEN/NODE from arriving packet; JOIN=1; OVF=0.
//  - Collision (slot valid, key differs OR same key same LR): stall=1, Ack_out=0 until slot
//    frees (without JOIN_OVF_EN). Packet in MM is never overwritten.
//  - Latency accept->Send_out: 1 cycle. Throughput 1 packet/cycle when Ack_in=1.
//  - Send_out&~Ack_in: PACKET_OUT and Send_out held stable; Ack_out=0.
//  - Simultaneous output pop and new accept in same cycle is legal (no bubble).
//  - MM_OCC saturates impossible by construction (max DEPTH); full MM just forces collisions.
//  - Width: all fields passed unmodified; no arithmetic on DATA.
// CONFIGURATION
//  JOIN_OVF_EN defined: a collision does not stall; the arriving packet is emitted next cycle
//    as a bypass packet with OVF=1, JOIN=1, DATA_R=0 (for recirculation by the router).
//  JOIN_OVF_EN undefined: collision stalls as above; OVF output bit always 0.
// STRUCTURE
//  - Package ddp_join_pkg: field widths/offsets, IN_W/OUT_W, MM entry typedef
//    {valid,gen,node,lr,dest,data}, packet typedefs.
//  - Sub-module jm_mem: DEPTH-entry register array, combinational read by index, one write
//    port with set/clear of valid, MM_OCC counter. Top holds compare, stall and output reg.
// TESTING
//  1 Reset: MR=1 for 5 cycles mid-traffic -> Send_out=0, Ack_out=0, MM_OCC=0, no output after.
//  2 Bypass: JOIN=0, NODE=1, DATA=4 -> 1 cycle later Send_out=1, DATA_L=4, DATA_R=0.
//  3 Interleaved join: A(NODE=1,LR=0,4), C(NODE=2,LR=0,2), B(NODE=1,LR=1,8), D(NODE=2,LR=1,3)
//    -> MM_OCC 1,2,1,0; outputs {L=4,R=8} node1 then {L=2,R=3} node2.
//  4 Reverse order: LR=1 DATA=8 first, LR=0 DATA=4 second -> DATA_L=4, DATA_R=8.
//  5 Collision: NODE=1 GEN=0 stored, then NODE=33 (same idx, IDX_W=5) -> Ack_out=0 until
//    NODE=1 partner frees slot; with JOIN_OVF_EN: NODE=33 emitted OVF=1, no stall.
//  6 Back-pressure: Ack_in=0 for 4 cycles with output pending -> PACKET_OUT stable, Ack_out=0,
//    no loss or duplicate after Ack_in=1.

Source files
------------

// File: rtl/ddp_join_pkg.sv
// ddp_join_pkg: field widths, packet layouts and matching-memory entry for the join stage.
package ddp_join_pkg;
  localparam int DEST_W = 3;
  localparam int GEN_W = 8;
  localparam int NODE_W = 7;
  localparam int DATA_W = 16;
  localparam int IDX_W = 5;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int IN_W = DEST_W + GEN_W + NODE_W + 4 + DATA_W;
  localparam int OUT_W = IN_W + DATA_W;
  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [GEN_W-1:0] gen;
    logic [NODE_W-1:0] node;
    logic lr;
    logic jn;
    logic ovf;
    logic rsv;
    logic [DATA_W-1:0] data;
  } in_pkt_t;
  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [GEN_W-1:0] gen;
    logic [NODE_W-1:0] node;
    logic lr;
    logic jn;
    logic ovf;
    logic rsv;
    logic [DATA_W-1:0] data_l;
    logic [DATA_W-1:0] data_r;
  } out_pkt_t;
  typedef struct packed {
    logic valid;
    logic [GEN_W-1:0] gen;
    logic [NODE_W-1:0] node;
    logic lr;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } mm_entry_t;
endpackage

// File: rtl/jm_mem.sv
// jm_mem: direct-mapped matching memory with combinational read, single write port and occupancy count.
module jm_mem
  import ddp_join_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  output mm_entry_t        rd,
  input  logic             we,
  input  mm_entry_t        wr,
  output logic [IDX_W:0]   occ
);
  localparam logic [IDX_W:0] ONE = 1;
  mm_entry_t mem [DEPTH];
  // Writes only ever flip an entry's valid bit, so occ moves by exactly one.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      occ <= '0;
    end else if (we) begin
      mem[idx] <= wr;
      occ <= wr.valid ? occ + ONE : occ - ONE;
    end
  assign rd = mem[idx];
endmodule

// File: rtl/join_match_unit.sv
// join_match_unit: pairs L/R operands by (GEN,NODE) in a matching memory and emits fused packets.
// Define JOIN_OVF_EN to emit colliding packets with OVF=1 instead of stalling.
module join_match_unit
  import ddp_join_pkg::*;
(
  input  logic             CLK,
  input  logic             MR,
  input  logic             Send_in,
  output logic             Ack_out,
  input  logic [IN_W-1:0]  PACKET_IN,
  output logic             Send_out,
  input  logic             Ack_in,
  output logic [OUT_W-1:0] PACKET_OUT,
  output logic [IDX_W:0]   MM_OCC
);
  in_pkt_t pin;
  out_pkt_t pout, nxt;
  mm_entry_t rd, wr;
  logic hit, coll, stall, acc, we, emit;
  logic unused_bits;
  assign pin = PACKET_IN;
  assign PACKET_OUT = pout;
  assign unused_bits = ^{rd.dest, pin.ovf};
  jm_mem u_mem (.clk(CLK), .rst(MR), .idx(pin.node[IDX_W-1:0]), .rd(rd), .we(we), .wr(wr), .occ(MM_OCC));
  always_comb begin
    hit = rd.valid && rd.gen == pin.gen && rd.node == pin.node && rd.lr != pin.lr;
    coll = pin.jn && rd.valid && !hit;
`ifdef JOIN_OVF_EN
    stall = 1'b0;
`else
    stall = coll;
`endif
    Ack_out = ~MR & (~Send_out | Ack_in) & ~stall;
    acc = Send_in & Ack_out;
    we = acc & pin.jn & ~coll;
    // Non-join bypasses, fusions and accepted collisions all produce an output.
    emit = acc & (~pin.jn | rd.valid);
    wr = '{valid: ~rd.valid, gen: pin.gen, node: pin.node, lr: pin.lr, dest: pin.dest, data: pin.data};
    nxt = '{dest: pin.dest, gen: pin.gen, node: pin.node, lr: 1'b0, jn: pin.jn, ovf: coll, rsv: pin.rsv,
            data_l: hit & pin.lr ? rd.data : pin.data,
            data_r: hit ? (pin.lr ? pin.data : rd.data) : '0};
  end
  always_ff @(posedge CLK or posedge MR)
    if (MR) begin
      Send_out <= 1'b0;
      pout <= '0;
    end else if (emit) begin
      Send_out <= 1'b1;
      pout <= nxt;
    end else if (Ack_in) Send_out <= 1'b0;
endmodule

// File: tb/tb_join_match_unit.sv
// tb_join_match_unit: directed self-checking bench for join_match_unit.
module tb_join_match_unit;
  import ddp_join_pkg::*;
  logic CLK = 0, MR = 1, Send_in = 0, Ack_in = 1;
  logic Ack_out, Send_out;
  logic [IN_W-1:0] PACKET_IN = '0;
  logic [OUT_W-1:0] PACKET_OUT;
  logic [IDX_W:0] MM_OCC;
  int checks = 0, errors = 0;
  out_pkt_t exp_p, e1, e2;

  join_match_unit dut (.CLK(CLK), .MR(MR), .Send_in(Send_in), .Ack_out(Ack_out), .PACKET_IN(PACKET_IN),
                       .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT), .MM_OCC(MM_OCC));
  always #5 CLK = ~CLK;

  function automatic in_pkt_t mk(input logic [2:0] d, input logic [7:0] g, input logic [6:0] n,
                                 input logic lr, input logic jn, input logic [15:0] dat);
    mk = '{dest: d, gen: g, node: n, lr: lr, jn: jn, ovf: 1'b0, rsv: 1'b0, data: dat};
  endfunction

  function automatic out_pkt_t eo(input logic [2:0] d, input logic [7:0] g, input logic [6:0] n,
                                  input logic jn, input logic ovf, input logic [15:0] dl, input logic [15:0] dr);
    eo = '{dest: d, gen: g, node: n, lr: 1'b0, jn: jn, ovf: ovf, rsv: 1'b0, data_l: dl, data_r: dr};
  endfunction

  task automatic put(input in_pkt_t p);
    @(negedge CLK);
    PACKET_IN = p;
    Send_in = 1;
    @(negedge CLK);
    Send_in = 0;
  endtask

  task automatic test_reset;
    checks++; if (Send_out !== 1'b0 || Ack_out !== 1'b0 || MM_OCC !== 0) begin errors++; $display("FAIL reset_init got send=%b ack=%b occ=%0d exp 0 0 0", Send_out, Ack_out, MM_OCC); end
    @(negedge CLK); MR = 0;
    put(mk(3'd1, 8'd0, 7'd5, 1'b0, 1'b1, 16'h0009));
    checks++; if (MM_OCC !== 1) begin errors++; $display("FAIL reset_prefill occ got %0d exp 1", MM_OCC); end
    @(negedge CLK); PACKET_IN = mk(3'd2, 8'd0, 7'd6, 1'b0, 1'b0, 16'h00AA); Send_in = 1;
    @(negedge CLK); MR = 1; #1;
    checks++; if (Send_out !== 1'b0 || Ack_out !== 1'b0 || MM_OCC !== 0 || PACKET_OUT !== '0) begin errors++; $display("FAIL reset_mid got send=%b ack=%b occ=%0d pkt=%h exp 0 0 0 0", Send_out, Ack_out, MM_OCC, PACKET_OUT); end
    repeat (5) @(negedge CLK);
    MR = 0; Send_in = 0;
    repeat (2) @(negedge CLK);
    checks++; if (Send_out !== 1'b0 || MM_OCC !== 0) begin errors++; $display("FAIL reset_after got send=%b occ=%0d exp 0 0", Send_out, MM_OCC); end
    put(mk(3'd1, 8'd0, 7'd5, 1'b1, 1'b1, 16'h0009));
    checks++; if (Send_out !== 1'b0 || MM_OCC !== 1) begin errors++; $display("FAIL reset_discard got send=%b occ=%0d exp 0 1", Send_out, MM_OCC); end
    put(mk(3'd4, 8'd0, 7'd5, 1'b0, 1'b1, 16'h0007));
    exp_p = eo(3'd4, 8'd0, 7'd5, 1'b1, 1'b0, 16'h0007, 16'h0009);
    checks++; if (Send_out !== 1'b1 || PACKET_OUT !== exp_p || MM_OCC !== 0) begin errors++; $display("FAIL reset_refuse got send=%b pkt=%h occ=%0d exp 1 %h 0", Send_out, PACKET_OUT, MM_OCC, exp_p); end
  endtask

  task automatic test_bypass;
    put(mk(3'd2, 8'd0, 7'd1, 1'b0, 1'b0, 16'd4));
    exp_p = eo(3'd2, 8'd0, 7'd1, 1'b0, 1'b0, 16'd4, 16'd0);
    checks++; if (Send_out !== 1'b1 || PACKET_OUT !== exp_p) begin errors++; $display("FAIL bypass got send=%b pkt=%h exp 1 %h", Send_out, PACKET_OUT, exp_p); end
    @(negedge CLK);
    checks++; if (Send_out !== 1'b0 || MM_OCC !== 0) begin errors++; $display("FAIL bypass_pop got send=%b occ=%0d exp 0 0", Send_out, MM_OCC); end
  endtask

  task automatic test_interleaved;
    put(mk(3'd1, 8'd0, 7'd1, 1'b0, 1'b1, 16'd4));
    checks++; if (MM_OCC !== 1 || Send_out !== 1'b0) begin errors++; $display("FAIL il_a got occ=%0d send=%b exp 1 0", MM_OCC, Send_out); end
    put(mk(3'd2, 8'd0, 7'd2, 1'b0, 1'b1, 16'd2));
    checks++; if (MM_OCC !== 2 || Send_out !== 1'b0) begin errors++; $display("FAIL il_c got occ=%0d send=%b exp 2 0", MM_OCC, Send_out); end
    put(mk(3'd3, 8'd0, 7'd1, 1'b1, 1'b1, 16'd8));
    exp_p = eo(3'd3, 8'd0, 7'd1, 1'b1, 1'b0, 16'd4, 16'd8);
    checks++; if (MM_OCC !== 1 || Send_out !== 1'b1 || PACKET_OUT !== exp_p) begin errors++; $display("FAIL il_b got occ=%0d send=%b pkt=%h exp 1 1 %h", MM_OCC, Send_out, PACKET_OUT, exp_p); end
    put(mk(3'd5, 8'd0, 7'd2, 1'b1, 1'b1, 16'd3));
    exp_p = eo(3'd5, 8'd0, 7'd2, 1'b1, 1'b0, 16'd2, 16'd3);
    checks++; if (MM_OCC !== 0 || Send_out !== 1'b1 || PACKET_OUT !== exp_p) begin errors++; $display("FAIL il_d got occ=%0d send=%b pkt=%h exp 0 1 %h", MM_OCC, Send_out, PACKET_OUT, exp_p); end
  endtask

  task automatic test_reverse;
    put(mk(3'd5, 8'd7, 7'd3, 1'b1, 1'b1, 16'd8));
    checks++; if (MM_OCC !== 1 || Send_out !== 1'b0) begin errors++; $display("FAIL rev_first got occ=%0d send=%b exp 1 0", MM_OCC, Send_out); end
    put(mk(3'd6, 8'd7, 7'd3, 1'b0, 1'b1, 16'd4));
    exp_p = eo(3'd6, 8'd7, 7'd3, 1'b1, 1'b0, 16'd4, 16'd8);
    checks++; if (MM_OCC !== 0 || PACKET_OUT !== exp_p || Send_out !== 1'b1) begin errors++; $display("FAIL rev_fuse got occ=%0d pkt=%h exp 0 %h", MM_OCC, PACKET_OUT, exp_p); end
  endtask

  task automatic test_collision;
    put(mk(3'd0, 8'd0, 7'd1, 1'b0, 1'b1, 16'h0011));
`ifdef JOIN_OVF_EN
    put(mk(3'd3, 8'd0, 7'd33, 1'b0, 1'b1, 16'h0022));
    exp_p = eo(3'd3, 8'd0, 7'd33, 1'b1, 1'b1, 16'h0022, 16'd0);
    checks++; if (Send_out !== 1'b1 || PACKET_OUT !== exp_p || MM_OCC !== 1) begin errors++; $display("FAIL coll_ovf got send=%b pkt=%h occ=%0d exp 1 %h 1", Send_out, PACKET_OUT, MM_OCC, exp_p); end
`else
    @(negedge CLK); PACKET_IN = mk(3'd3, 8'd0, 7'd33, 1'b0, 1'b1, 16'h0022); Send_in = 1; #1;
    checks++; if (Ack_out !== 1'b0) begin errors++; $display("FAIL coll_stall ack got %b exp 0", Ack_out); end
    repeat (3) @(negedge CLK);
    checks++; if (Ack_out !== 1'b0 || Send_out !== 1'b0 || MM_OCC !== 1) begin errors++; $display("FAIL coll_hold got ack=%b send=%b occ=%0d exp 0 0 1", Ack_out, Send_out, MM_OCC); end
    Send_in = 0;
`endif
    put(mk(3'd2, 8'd0, 7'd1, 1'b1, 1'b1, 16'h0033));
    exp_p = eo(3'd2, 8'd0, 7'd1, 1'b1, 1'b0, 16'h0011, 16'h0033);
    checks++; if (Send_out !== 1'b1 || PACKET_OUT !== exp_p || MM_OCC !== 0) begin errors++; $display("FAIL coll_free got send=%b pkt=%h occ=%0d exp 1 %h 0", Send_out, PACKET_OUT, MM_OCC, exp_p); end
`ifndef JOIN_OVF_EN
    put(mk(3'd3, 8'd0, 7'd33, 1'b0, 1'b1, 16'h0022));
    checks++; if (MM_OCC !== 1) begin errors++; $display("FAIL coll_store occ got %0d exp 1", MM_OCC); end
    @(negedge CLK); PACKET_IN = mk(3'd3, 8'd0, 7'd33, 1'b0, 1'b1, 16'h0044); Send_in = 1; #1;
    checks++; if (Ack_out !== 1'b0) begin errors++; $display("FAIL coll_samelr ack got %b exp 0", Ack_out); end
    @(negedge CLK); Send_in = 0;
    put(mk(3'd1, 8'd0, 7'd33, 1'b1, 1'b1, 16'h0055));
    exp_p = eo(3'd1, 8'd0, 7'd33, 1'b1, 1'b0, 16'h0022, 16'h0055);
    checks++; if (PACKET_OUT !== exp_p || MM_OCC !== 0) begin errors++; $display("FAIL coll_kept got pkt=%h occ=%0d exp %h 0", PACKET_OUT, MM_OCC, exp_p); end
`endif
  endtask

  task automatic test_back_to_back;
    @(negedge CLK); Ack_in = 0;
    put(mk(3'd1, 8'd0, 7'd10, 1'b0, 1'b0, 16'h00A1));
    e1 = eo(3'd1, 8'd0, 7'd10, 1'b0, 1'b0, 16'h00A1, 16'd0);
    e2 = eo(3'd2, 8'd0, 7'd11, 1'b0, 1'b0, 16'h00B2, 16'd0);
    PACKET_IN = mk(3'd2, 8'd0, 7'd11, 1'b0, 1'b0, 16'h00B2); Send_in = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (Ack_out !== 1'b0 || Send_out !== 1'b1 || PACKET_OUT !== e1) begin errors++; $display("FAIL bp_hold%0d got ack=%b send=%b pkt=%h exp 0 1 %h", i, Ack_out, Send_out, PACKET_OUT, e1); end
      @(negedge CLK);
    end
    Ack_in = 1; #1;
    checks++; if (Ack_out !== 1'b1) begin errors++; $display("FAIL bp_release ack got %b exp 1", Ack_out); end
    @(negedge CLK);
    checks++; if (Send_out !== 1'b1 || PACKET_OUT !== e2) begin errors++; $display("FAIL bp_next got send=%b pkt=%h exp 1 %h", Send_out, PACKET_OUT, e2); end
    Send_in = 0;
    @(negedge CLK);
    checks++; if (Send_out !== 1'b0) begin errors++; $display("FAIL bp_nodup send got %b exp 0", Send_out); end
    for (int i = 0; i < 3; i++) begin
      PACKET_IN = mk(3'd4, 8'd1, 7'd20, 1'b0, 1'b0, 16'(i + 1)); Send_in = 1;
      @(negedge CLK);
      exp_p = eo(3'd4, 8'd1, 7'd20, 1'b0, 1'b0, 16'(i + 1), 16'd0);
      checks++; if (Send_out !== 1'b1 || PACKET_OUT !== exp_p) begin errors++; $display("FAIL stream%0d got send=%b pkt=%h exp 1 %h", i, Send_out, PACKET_OUT, exp_p); end
    end
    Send_in = 0;
    @(negedge CLK);
    checks++; if (Send_out !== 1'b0) begin errors++; $display("FAIL stream_end send got %b exp 0", Send_out); end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    test_reset;
    test_bypass;
    test_interleaved;
    test_reverse;
    test_collision;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
